// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared types and decode table for the EX-stage multiply/divide unit
//   muldiv_op_t    : operation selector driven by EX (md_op_i)
//   muldiv_state_t : IDLE / BUSY / DONE sequencing of the unit
//   hilo_t         : {en, hi, lo} bundle for HILO write-path consumers
//   md_decode      : funct code (MULT_OP..DIVU_OP) to muldiv_op_t mapping used by EX
package ex_muldiv_pkg;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} muldiv_state_t;
  localparam int HILO_W = 32;
  typedef struct packed {
    logic              en;
    logic [HILO_W-1:0] hi;
    logic [HILO_W-1:0] lo;
  } hilo_t;
  localparam logic [5:0] MULT_OP  = 6'h18;
  localparam logic [5:0] MULTU_OP = 6'h19;
  localparam logic [5:0] DIV_OP   = 6'h1a;
  localparam logic [5:0] DIVU_OP  = 6'h1b;
  function automatic muldiv_op_t md_decode(input logic [5:0] funct);
    case (funct)
      MULTU_OP: return MD_MULTU;
      DIV_OP:   return MD_DIV;
      DIVU_OP:  return MD_DIVU;
      default:  return MD_MULT;
    endcase
  endfunction
endpackage

// File: rtl/ex_muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-divide step
//   rem_in  : (DATA_W+1)-bit partial remainder (previous remainder shifted left with next dividend bit)
//   divisor : DATA_W-bit divisor magnitude
//   rem_out : next remainder (always below the divisor, so DATA_W bits suffice)
//   q_bit   : quotient bit produced by this step
module muldiv_div_step #(parameter int DATA_W = 32) (
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);
  logic [DATA_W-1:0] diff;
  assign q_bit = rem_in >= {1'b0, divisor};
  // Truncation is safe: the difference is only kept when it is below the divisor.
  assign diff = rem_in[DATA_W-1:0] - divisor;
  assign rem_out = q_bit ? diff : rem_in[DATA_W-1:0];
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU
//   clk, rst (async, active-low)
//   md_start_i/md_op_i/md_oprd1_i/md_oprd2_i : level-held request from EX, operands captured once
//   md_annul_i       : flush, aborts in any state (priority over start)
//   md_hi_o/md_lo_o  : product halves, or remainder/quotient
//   md_valid_o       : result valid, held in DONE until start drops
//   stallreq_from_md : EX stall request while the operation is in flight
//   Option macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply instead of shift-add.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic              md_start_i,
  input  logic [1:0]        md_op_i,
  input  logic [DATA_W-1:0] md_oprd1_i,
  input  logic [DATA_W-1:0] md_oprd2_i,
  input  logic              md_annul_i,
  output logic [DATA_W-1:0] md_hi_o,
  output logic [DATA_W-1:0] md_lo_o,
  output logic              md_valid_o,
  output logic              stallreq_from_md
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  muldiv_state_t state_q, state_d;
  muldiv_op_t op_in;
  logic [DATA_W-1:0] b_q, rem_q, hi_q, lo_q, a_mag, b_mag, quo_next, rem_next, quo_res, rem_res;
  logic [2*DATA_W-1:0] acc_q, mul_next, mul_res, fast_prod;
  logic [DATA_W:0] mul_sum;
  logic [CW-1:0] cnt_q;
  logic is_div, is_sgn, is_div_q, neg_q, neg_r, sa, sb, div0, launch, fast, q_bit;
  assign op_in = muldiv_op_t'(md_op_i);
  assign is_div = op_in == MD_DIV || op_in == MD_DIVU;
  assign is_sgn = op_in == MD_MULT || op_in == MD_DIV;
  assign sa = is_sgn & md_oprd1_i[DATA_W-1];
  assign sb = is_sgn & md_oprd2_i[DATA_W-1];
  // The most-negative value negates to itself, which read unsigned is the correct magnitude.
  assign a_mag = sa ? -md_oprd1_i : md_oprd1_i;
  assign b_mag = sb ? -md_oprd2_i : md_oprd2_i;
  assign div0 = is_div && md_oprd2_i == '0;
  assign launch = state_q == MD_IDLE && md_start_i && !md_annul_i;
`ifdef MULDIV_FAST_MUL_EN
  assign fast = !is_div;
  // Sign-extended unsigned multiply gives the exact low 2W bits of the signed product.
  assign fast_prod = {{DATA_W{sa}}, md_oprd1_i} * {{DATA_W{sb}}, md_oprd2_i};
`else
  assign fast = 1'b0;
  assign fast_prod = '0;
`endif
  // Shift-add: multiplier sits in the low half of acc and is consumed LSB first.
  assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, b_q & {DATA_W{acc_q[0]}}};
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};
  // Restoring divide: dividend leaves the top of acc's low half while quotient bits enter at the bottom.
  muldiv_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  ({rem_q, acc_q[DATA_W-1]}),
    .divisor (b_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );
  assign quo_next = {acc_q[DATA_W-2:0], q_bit};
  assign mul_res = neg_q ? -mul_next : mul_next;
  assign quo_res = neg_q ? -quo_next : quo_next;
  assign rem_res = neg_r ? -rem_next : rem_next;
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md_start_i) state_d = (div0 || fast) ? MD_DONE : MD_BUSY;
      MD_BUSY: if (cnt_q == LAST) state_d = MD_DONE;
      MD_DONE: if (!md_start_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (md_annul_i) state_d = MD_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= MD_IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      is_div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (launch) begin
      acc_q <= {{DATA_W{1'b0}}, is_div ? a_mag : b_mag};
      b_q <= is_div ? b_mag : a_mag;
      rem_q <= '0;
      cnt_q <= '0;
      is_div_q <= is_div;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      if (div0) {hi_q, lo_q} <= {md_oprd1_i, {DATA_W{1'b1}}};
      else if (fast) {hi_q, lo_q} <= fast_prod;
    end else if (state_q == MD_BUSY && !md_annul_i) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= is_div_q ? {acc_q[2*DATA_W-1:DATA_W], quo_next} : mul_next;
      rem_q <= rem_next;
      if (cnt_q == LAST) {hi_q, lo_q} <= is_div_q ? {rem_res, quo_res} : mul_res;
    end
  end
  assign md_hi_o = hi_q;
  assign md_lo_o = lo_q;
  assign md_valid_o = state_q == MD_DONE;
  assign stallreq_from_md = launch || state_q == MD_BUSY;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv (DATA_W=32) with a plain-arithmetic reference model
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, annul = 1'b0;
  logic [1:0] op = 2'd0;
  logic [W-1:0] a = '0, b = '0, hi, lo;
  logic valid, stall, prev_v = 1'b0;
  int asserts = 0, fails = 0;
  logic [63:0] sb_q[$];
  always #5 clk = ~clk;
  ex_muldiv #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .md_start_i(start), .md_op_i(op),
    .md_oprd1_i(a), .md_oprd2_i(b), .md_annul_i(annul),
    .md_hi_o(hi), .md_lo_o(lo), .md_valid_o(valid), .stallreq_from_md(stall)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (o == 2'd0) return 64'(sx * sy);
    if (o == 2'd1) return ux * uy;
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (o == 2'd2) begin
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    uq = ux / uy;
    ur = ux % uy;
    return {ur[31:0], uq[31:0]};
  endfunction
  always @(negedge clk) begin
    logic [63:0] e;
    if (valid && !prev_v) begin
      if (sb_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
      else begin
        e = sb_q.pop_front();
        check("result", {hi, lo}, e);
      end
    end
    prev_v <= valid;
  end
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [63:0] e);
    int lat, st, el;
    el = (o[1] && y == 0) || (!o[1] && FAST) ? 1 : W + 1;
    @(posedge clk);
    #1;
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(e);
    lat = 0; st = 0;
    @(negedge clk);
    while (!valid && lat < 100) begin
      if (stall) st++;
      lat++;
      @(negedge clk);
    end
    check("latency", 64'(lat), 64'(el));
    check("stall_cycles", 64'(st), 64'(el));
    check("stall_in_done", 64'(stall), 64'd0);
    a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    check("held_valid", 64'(valid), 64'd1);
    check("held_result", {hi, lo}, e);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("valid_drop", 64'(valid), 64'd0);
  endtask
  initial begin
    logic [1:0] o;
    logic [W-1:0] x, y;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst = 1'b1;
    run_op(MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
    run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFE});
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, {32'd1, 32'hFFFFFFFE});
    run_op(MD_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    @(posedge clk);
    #1;
    op = MD_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul_valid", 64'(valid), 64'd0);
    check("annul_stall", 64'(stall), 64'd0);
    annul = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check("annul_idle", 64'(valid), 64'd0);
    run_op(MD_DIVU, 32'd9, 32'd3, {32'd0, 32'd3});
    @(posedge clk);
    #1;
    op = MD_DIV; a = 32'hFFFFFF9C; b = 32'd7; start = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0; start = 1'b0;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_op(MD_DIV, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2});
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0: y = '0;
        1: x = 32'h80000000;
        2: y = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op(o, x, y, model(o, x, y));
    end
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit sitting beside the EX-stage ALU. It executes MULT, MULTU, DIV and DIVU on DATA_W-bit operands and produces a 2×DATA_W-bit HI/LO result for the HILO write path. It raises a stall request toward the pipeline controller while the operation is in flight. Operands are captured once, and the result is held until EX advances. A flush can abort the operation in any cycle.

## Interface

- DATA_W, 32, operand and HI/LO half width; legal values are 8..64, even.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- md_start_i  input  1  EX holds a mul/div instruction; level-held until the result is taken.
- md_op_i  input  2  muldiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- md_oprd1_i  input  DATA_W  rs operand; the multiplicand or dividend.
- md_oprd2_i  input  DATA_W  rt operand; the multiplier or divisor.
- md_annul_i  input  1  flush; aborts the current operation.
- md_hi_o  output  DATA_W  result high half: product[2W-1:W], or the remainder.
- md_lo_o  output  DATA_W  result low half: product[W-1:0], or the quotient.
- md_valid_o  output  1  md_hi_o and md_lo_o are valid.
- stallreq_from_md  output  1  EX must stall.

## Operation

- State machine states: MD_IDLE, MD_BUSY, MD_DONE, encoded as muldiv_state_t.
- **MD_IDLE**
  - On md_start_i=1 and md_annul_i=0: latch the op and both operands, clear the counter, go to MD_BUSY.
  - Divide with divisor 0: skip iteration and go directly to MD_DONE with lo = all ones, hi = dividend (raw, unsigned).
- **MD_BUSY**
  - One iteration per cycle; a counter of width $clog2(DATA_W)+1 counts 0..DATA_W-1.
  - After iteration DATA_W-1, apply sign correction, register HI/LO, go to MD_DONE.
- **MD_DONE**
  - md_valid_o=1 and the result is held stable.
  - Return to MD_IDLE when md_start_i=0, i.e. when EX has advanced.
  - If md_start_i is still 1, stay in MD_DONE; do not restart.
- **md_annul_i=1** in any state: next state is MD_IDLE, md_valid_o=0 from the next cycle, and no result is produced. Annul has priority over start.
- **Signed ops** (MD_MULT, MD_DIV):
  - Iterate on absolute values.
  - Product and quotient are negated when sign(a) XOR sign(b).
  - Remainder takes sign(a).
  - The most-negative operand is handled by treating its absolute value as a W-bit unsigned magnitude.
  - DIV of -2^(W-1) by -1 gives quotient -2^(W-1), remainder 0 (wrap).
- **Divide** is restoring, one quotient bit per cycle, with a (W+1)-bit partial remainder.
- **Multiply** (iterative) is shift-add, one multiplier bit per cycle, with a 2W-bit accumulator.
- **stallreq_from_md** = (MD_IDLE & md_start_i & ~md_annul_i) | MD_BUSY. It is combinational and is 0 in MD_DONE.

## Timing

- Reset values: state MD_IDLE, md_hi_o=0, md_lo_o=0, md_valid_o=0, stallreq_from_md=0.
- Iterative op with start seen in cycle 0:
  - stall is asserted in cycles 0..DATA_W.
  - md_valid_o rises in cycle DATA_W+1.
  - Total latency is DATA_W+1 cycles.
- Divide by zero, and fast multiply: stall in cycle 0 only; md_valid_o in cycle 1.
- Operand changes after cycle 0 are ignored.
- Reset mid-operation clears everything immediately; the operation is lost.

## Configuration

- MULDIV_FAST_MUL_EN defined:
  - MULT and MULTU use a single-cycle combinational multiply, registered directly into MD_DONE (latency 1).
  - Divide is unchanged.
- Undefined: multiply uses the iterative shift-add path (latency DATA_W+1) and no DSP multiplier is inferred.

## Structure

- project_types package holds:
  - muldiv_op_t enum;
  - muldiv_state_t enum;
  - a hilo result struct {en, hi, lo}, for consumers that need it.
- decode_table holds the MULT_OP, MULTU_OP, DIV_OP and DIVU_OP to muldiv_op_t mapping used by EX.
- One sub-module, muldiv_div_step, implements one restoring-divide step combinationally:
  - inputs: partial remainder, divisor;
  - outputs: next remainder, quotient bit.

## Test plan

All scenarios use DATA_W=32.

- DIVU 100 / 7 → stall for 33 cycles, then lo=14, hi=2, valid held until start drops.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT 0xFFFFFFFF × 2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU 0xFFFFFFFF × 2 → hi=1, lo=0xFFFFFFFE.
- Latency check: with MULTU, valid at cycle 1 when MULDIV_FAST_MUL_EN is defined, cycle 33 without it.
- DIVU 5 / 0 → valid at cycle 1, lo=0xFFFFFFFF, hi=5, stall lasts 1 cycle.
- Annul at cycle 10 of a DIVU → MD_IDLE next cycle with valid=0. A new DIVU 9 / 3 started next gives lo=3, hi=0.
- rst low at cycle 5 of a DIV → all outputs 0 immediately. After release, a fresh op completes correctly.
